// File: rtl/gg_emulation_insert.sv
// NAL emulation prevention inserter: expands a 16-byte/cycle RBSP stream and repacks it into 16-byte words.
// Optional GG_EMU_INSERT_TRAIL_EN appends 0x03 after a NAL whose final emitted byte is 0x00.
module gg_emulation_insert (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] iport,
  input  logic         iport_valid,
  output logic         iport_ready,
  input  logic         iport_last,
  input  logic [4:0]   iport_len,
  output logic [127:0] oport,
  output logic         oport_valid,
  input  logic         oport_ready,
  output logic         oport_last,
  output logic [4:0]   oport_len
);

`ifdef GG_EMU_INSERT_TRAIL_EN
  // One spare byte: a 24-byte expansion accepted at fill 24 may still carry the trailing 0x03.
  localparam int unsigned BUFB = 49;
  localparam int unsigned EXPB = 25;
`else
  localparam int unsigned BUFB = 48;
  localparam int unsigned EXPB = 24;
`endif
  localparam int unsigned BW = 8 * BUFB;
  localparam int unsigned EW = 8 * EXPB;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t          state;
  logic [1:0]      zc;
  logic [5:0]      fill;
  logic [BW-1:0]   bufq;

  logic [4:0]      nbytes;
  logic [127:0]    in_w;
  logic [7:0]      b;
  logic [EW-1:0]   ex_acc;
  logic [EW-1:0]   ex_vec;
  logic [4:0]      ex_cnt;
  logic [1:0]      zc_ex;

  // Byte-serial expansion of the input word; ex_vec is left-justified with zero tail.
  always_comb begin
    nbytes = (iport_last && iport_len != 5'd0 && iport_len <= 5'd16) ? iport_len : 5'd16;
    ex_acc = '0;
    ex_cnt = '0;
    zc_ex  = zc;
    in_w   = iport;
    b      = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      b    = in_w[127:120];
      in_w = in_w << 8;
      if (i < 32'(nbytes)) begin
        if (zc_ex == 2'd2 && b <= 8'h03) begin
          ex_acc = {ex_acc[EW-9:0], 8'h03};
          ex_cnt = ex_cnt + 5'd1;
          zc_ex  = 2'd0;
        end
        ex_acc = {ex_acc[EW-9:0], b};
        ex_cnt = ex_cnt + 5'd1;
        if (b != 8'h00)
          zc_ex = 2'd0;
        else if (zc_ex != 2'd2)
          zc_ex = zc_ex + 2'd1;
      end
    end
`ifdef GG_EMU_INSERT_TRAIL_EN
    if (iport_last && zc_ex != 2'd0) begin
      ex_acc = {ex_acc[EW-9:0], 8'h03};
      ex_cnt = ex_cnt + 5'd1;
    end
`endif
    ex_vec = ex_acc << (8 * (EXPB - 32'(ex_cnt)));
  end

  logic            accept;
  logic [4:0]      drain;
  logic [5:0]      mid;
  logic [5:0]      fill_n;
  logic [BW-1:0]   buf_n;

  always_comb begin
    iport_ready = (state == RUN) && (fill <= 6'd24) && !reset;
    oport_valid = (fill >= 6'd16) || (state == FLUSH && fill != '0);
    oport_last  = (state == FLUSH) && (fill != '0) && (fill <= 6'd16);
    oport_len   = (fill >= 6'd16) ? 5'd16 : fill[4:0];
    oport       = bufq[BW-1 -: 128];
    accept      = iport_valid && iport_ready;
    drain       = (oport_valid && oport_ready) ? oport_len : '0;
    mid         = fill - {1'b0, drain};
    // Bytes past fill are always zero, so the new expansion can simply be ORed in at the drained tail.
    buf_n       = bufq << (8 * 32'(drain));
    if (accept)
      buf_n = buf_n | ({ex_vec, {(BW-EW){1'b0}}} >> (8 * 32'(mid)));
    fill_n      = mid + (accept ? {1'b0, ex_cnt} : 6'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      zc    <= '0;
      fill  <= '0;
      bufq  <= '0;
    end else begin
      bufq <= buf_n;
      fill <= fill_n;
      case (state)
        RUN: begin
          if (accept) begin
            zc <= zc_ex;
            if (iport_last)
              state <= FLUSH;
          end
        end
        FLUSH: begin
          if (fill_n == '0) begin
            zc    <= '0;
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
